sim_ps_clk_ctrl: RTL and testbench



---
 rtl/sim_ps_pkg.sv | 46 ++++
 rtl/sim_ps_phase_gen.sv | 94 +++++++++
 rtl/sim_ps_clk_ctrl.sv | 117 +++++++++++
 tb/tb_sim_ps_clk_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ps_pkg.sv
// Shared definitions for the simulation phase-shift clock controller.
// Contents:
//   ps_state_e  - phase-shift handshake states
//   phase_width - bit width of a phase value for a given divide ratio
//   phase_step  - one modulo-DIVIDE increment/decrement of the phase offset
package sim_ps_pkg;

  typedef enum logic [0:0] {
    PS_IDLE = 1'b0,
    PS_WAIT = 1'b1
  } ps_state_e;

  // Width of PHASE; never narrower than one bit.
  function automatic int unsigned phase_width(input int unsigned divide);
    int unsigned w;
    w = $clog2(divide);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // One phase step with wrap at both ends of 0..divide-1.
  function automatic int unsigned phase_step(input int unsigned phase,
                                             input logic incdec,
                                             input int unsigned divide);
    int unsigned res;
    if (incdec) begin
      if (phase == divide - 32'd1) begin
        res = 32'd0;
      end else begin
        res = phase + 32'd1;
      end
    end else begin
      if (phase == 32'd0) begin
        res = divide - 32'd1;
      end else begin
        res = phase - 32'd1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sim_ps_phase_gen.sv
// Divided clock generator with lock delay.
// Ports:
//   clk     in  reference clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   phase   in  phase offset that the PHASE register holds after the
//               coming edge (its next-state value), so CLK_OUT tracks
//               the post-edge phase
//   clk_out out registered divided clock, 0 until locked
//   locked  out high from edge LOCK_CYCLES after reset release onwards
module sim_ps_phase_gen
  import sim_ps_pkg::*;
#(
  parameter int unsigned DIVIDE      = 4,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(DIVIDE)-1:0] phase,
  output logic                      clk_out,
  output logic                      locked
);

  localparam int unsigned PW = phase_width(DIVIDE);
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [PW-1:0] CNT_MAX   = PW'(DIVIDE - 32'd1);
  localparam logic [PW-1:0] CNT_ONE   = PW'(32'd1);
  localparam logic [PW:0]   DIV_W     = (PW+1)'(DIVIDE);
  localparam logic [PW:0]   HALF_W    = (PW+1)'(DIVIDE / 32'd2);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 32'd1);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_CYCLES);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(32'd1);

  logic [PW-1:0] cnt_r;
  logic [PW-1:0] cnt_nxt_s;
  logic [LW-1:0] lock_cnt_r;
  logic [LW-1:0] lock_cnt_nxt_s;
  logic          locked_r;
  logic          locked_nxt_s;
  logic [PW:0]   diff_s;
  logic          clk_out_r;
  logic          clk_out_nxt_s;

  // Next tick count, lock progress and output level from post-edge values.
  always_comb begin
    cnt_nxt_s      = cnt_r;
    lock_cnt_nxt_s = lock_cnt_r;
    locked_nxt_s   = locked_r;
    diff_s         = '0;
    clk_out_nxt_s  = 1'b0;

    if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end

    if (lock_cnt_r != LOCK_MAX) begin
      lock_cnt_nxt_s = lock_cnt_r + LOCK_ONE;
    end else begin
      lock_cnt_nxt_s = lock_cnt_r;
    end

    // Sticky: once the count passes LOCK_LAST, lock holds until reset.
    locked_nxt_s = locked_r | (lock_cnt_r == LOCK_LAST);

    // (cnt - phase) mod DIVIDE, one bit wider so DIVIDE itself fits.
    if ({1'b0, cnt_nxt_s} >= {1'b0, phase}) begin
      diff_s = {1'b0, cnt_nxt_s} - {1'b0, phase};
    end else begin
      diff_s = {1'b0, cnt_nxt_s} + DIV_W - {1'b0, phase};
    end

    clk_out_nxt_s = locked_nxt_s & (diff_s < HALF_W);
  end

  // Tick counter, lock counter and output clock registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      lock_cnt_r <= '0;
      locked_r   <= 1'b0;
      clk_out_r  <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
      locked_r   <= locked_nxt_s;
      clk_out_r  <= clk_out_nxt_s;
    end
  end

  assign clk_out = clk_out_r;
  assign locked  = locked_r;

endmodule

// File: rtl/sim_ps_clk_ctrl.sv
// Divided clock source with MMCM-style dynamic phase-shift handshake.
// Ports:
//   CLK      in  reference clock, rising edge
//   R_N      in  asynchronous active-low reset
//   PSEN     in  one-cycle phase-shift request (ignored unless locked and idle)
//   PSINCDEC in  direction with PSEN: 1 increment, 0 decrement
//   PSDONE   out one-cycle pulse, PS_LATENCY edges after the accepting edge
//   PHASE    out current phase offset 0..DIVIDE-1 in CLK cycles
//   CLK_OUT  out registered divided, phase-shifted clock
//   LOCKED   out output clock valid
module sim_ps_clk_ctrl
  import sim_ps_pkg::*;
#(
  parameter int unsigned DIVIDE      = 4,
  parameter int unsigned PS_LATENCY  = 12,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                      CLK,
  input  logic                      R_N,
  input  logic                      PSEN,
  input  logic                      PSINCDEC,
  output logic                      PSDONE,
  output logic [$clog2(DIVIDE)-1:0] PHASE,
  output logic                      CLK_OUT,
  output logic                      LOCKED
);

  localparam int unsigned PW   = phase_width(DIVIDE);
  localparam int unsigned LATW = $clog2(PS_LATENCY + 1);
  localparam logic [LATW-1:0] LAT_ONE  = LATW'(32'd1);
  localparam logic [LATW-1:0] LAT_DONE = LATW'(PS_LATENCY);

  ps_state_e     state_r;
  ps_state_e     state_nxt_s;
  logic [LATW-1:0] lat_r;
  logic [LATW-1:0] lat_nxt_s;
  logic          incdec_r;
  logic          incdec_nxt_s;
  logic [PW-1:0] phase_r;
  logic [PW-1:0] phase_nxt_s;
  logic          psdone_r;
  logic          psdone_nxt_s;
  logic          locked_s;
  logic          clk_out_s;

  // Handshake next-state logic. lat_r holds the number of edges seen since
  // the accepting edge, so the shift lands when it reaches PS_LATENCY.
  always_comb begin
    state_nxt_s  = state_r;
    lat_nxt_s    = lat_r;
    incdec_nxt_s = incdec_r;
    phase_nxt_s  = phase_r;
    psdone_nxt_s = 1'b0;

    case (state_r)
      PS_IDLE: begin
        if (PSEN && locked_s) begin
          state_nxt_s  = PS_WAIT;
          incdec_nxt_s = PSINCDEC;
          lat_nxt_s    = LAT_ONE;
        end else begin
          state_nxt_s = PS_IDLE;
        end
      end
      PS_WAIT: begin
        // PSEN is deliberately not looked at here: no queueing.
        if (lat_r == LAT_DONE) begin
          state_nxt_s  = PS_IDLE;
          lat_nxt_s    = '0;
          psdone_nxt_s = 1'b1;
          phase_nxt_s  = PW'(phase_step(32'(phase_r), incdec_r, DIVIDE));
        end else begin
          lat_nxt_s = lat_r + LAT_ONE;
        end
      end
      default: begin
        state_nxt_s = PS_IDLE;
        lat_nxt_s   = '0;
      end
    endcase
  end

  // Handshake state, latency counter and phase registers.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      state_r  <= PS_IDLE;
      lat_r    <= '0;
      incdec_r <= 1'b0;
      phase_r  <= '0;
      psdone_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      lat_r    <= lat_nxt_s;
      incdec_r <= incdec_nxt_s;
      phase_r  <= phase_nxt_s;
      psdone_r <= psdone_nxt_s;
    end
  end

  // Next-phase value feeds the generator so CLK_OUT uses the post-edge phase.
  sim_ps_phase_gen #(
    .DIVIDE      (DIVIDE),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_phase_gen (
    .clk     (CLK),
    .rst_n   (R_N),
    .phase   (phase_nxt_s),
    .clk_out (clk_out_s),
    .locked  (locked_s)
  );

  assign PSDONE  = psdone_r;
  assign PHASE   = phase_r;
  assign CLK_OUT = clk_out_s;
  assign LOCKED  = locked_s;

endmodule

// File: tb/tb_sim_ps_clk_ctrl.sv
// Directed testbench for sim_ps_clk_ctrl.
// Instance a: DIVIDE=4, PS_LATENCY=12, LOCK_CYCLES=16 (main scenarios).
// Instance b: DIVIDE=2, PS_LATENCY=2; instance c: DIVIDE=8, PS_LATENCY=2.
// All instances share CLK and R_N. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_sim_ps_clk_ctrl;

  logic       clk;
  logic       r_n;
  logic       psen_a, incdec_a, psdone_a, clk_out_a, locked_a;
  logic [1:0] phase_a;
  logic       psen_b, incdec_b, psdone_b, clk_out_b, locked_b;
  logic [0:0] phase_b;
  logic       psen_c, incdec_c, psdone_c, clk_out_c, locked_c;
  logic [2:0] phase_c;

  int n_checks;
  int n_fail;
  int ecount;   // rising edges since the last reset release

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sim_ps_clk_ctrl #(.DIVIDE(4), .PS_LATENCY(12), .LOCK_CYCLES(16)) dut_a (
    .CLK(clk), .R_N(r_n), .PSEN(psen_a), .PSINCDEC(incdec_a),
    .PSDONE(psdone_a), .PHASE(phase_a), .CLK_OUT(clk_out_a), .LOCKED(locked_a)
  );

  sim_ps_clk_ctrl #(.DIVIDE(2), .PS_LATENCY(2), .LOCK_CYCLES(16)) dut_b (
    .CLK(clk), .R_N(r_n), .PSEN(psen_b), .PSINCDEC(incdec_b),
    .PSDONE(psdone_b), .PHASE(phase_b), .CLK_OUT(clk_out_b), .LOCKED(locked_b)
  );

  sim_ps_clk_ctrl #(.DIVIDE(8), .PS_LATENCY(2), .LOCK_CYCLES(16)) dut_c (
    .CLK(clk), .R_N(r_n), .PSEN(psen_c), .PSINCDEC(incdec_c),
    .PSDONE(psdone_c), .PHASE(phase_c), .CLK_OUT(clk_out_c), .LOCKED(locked_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic test_reset();
    logic [3:0] pat;
    pat = 4'b0011;   // CLK_OUT for cnt 0,1,2,3 at phase 0: 1,1,0,0
    r_n = 1'b0;
    psen_a = 1'b0; incdec_a = 1'b0;
    psen_b = 1'b0; incdec_b = 1'b0;
    psen_c = 1'b0; incdec_c = 1'b0;
    repeat (10) tick();
    n_checks++; if (psdone_a !== 1'b0) begin n_fail++; $display("FAIL reset_psdone: got %b expected 0", psdone_a); end
    n_checks++; if (phase_a !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase_a); end
    n_checks++; if (clk_out_a !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out: got %b expected 0", clk_out_a); end
    n_checks++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked_a); end
    r_n = 1'b1;
    ecount = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e <= 15) begin
        n_checks++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL prelock_locked edge %0d: got %b expected 0", e, locked_a); end
        n_checks++; if (clk_out_a !== 1'b0) begin n_fail++; $display("FAIL prelock_clk_out edge %0d: got %b expected 0", e, clk_out_a); end
      end else begin
        n_checks++; if (locked_a !== 1'b1) begin n_fail++; $display("FAIL lock_edge16: got %b expected 1", locked_a); end
        n_checks++; if (clk_out_a !== 1'b1) begin n_fail++; $display("FAIL clk_out_edge16: got %b expected 1", clk_out_a); end
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (clk_out_a !== pat[ecount % 4]) begin
        n_fail++; $display("FAIL lock_pattern cnt %0d: got %b expected %b", ecount % 4, clk_out_a, pat[ecount % 4]);
      end
    end
  endtask

  task automatic test_increment();
    logic [3:0] pat;
    pat = 4'b0110;   // phase 1: cnt 0,1,2,3 -> 0,1,1,0
    psen_a = 1'b1; incdec_a = 1'b1;
    tick();
    psen_a = 1'b0; incdec_a = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      n_checks++;
      if (psdone_a !== (k == 12)) begin
        n_fail++; $display("FAIL inc_psdone edge +%0d: got %b expected %b", k, psdone_a, (k == 12));
      end
      if (k == 12) begin
        n_checks++; if (phase_a !== 2'd1) begin n_fail++; $display("FAIL inc_phase: got %0d expected 1", phase_a); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (clk_out_a !== pat[ecount % 4]) begin
        n_fail++; $display("FAIL inc_pattern cnt %0d: got %b expected %b", ecount % 4, clk_out_a, pat[ecount % 4]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] dirs;
    logic [1:0] exp_ph [3];
    int pulses;
    dirs = 3'b100;                       // step0 dec, step1 dec, step2 inc
    exp_ph[0] = 2'd0; exp_ph[1] = 2'd3; exp_ph[2] = 2'd0;
    for (int s = 0; s < 3; s++) begin
      psen_a = 1'b1; incdec_a = dirs[s];
      tick();
      psen_a = 1'b0; incdec_a = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 12; k++) begin
        tick();
        if (psdone_a === 1'b1) pulses++;
      end
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL wrap_pulses step %0d: got %0d expected 1", s, pulses); end
      n_checks++; if (phase_a !== exp_ph[s]) begin n_fail++; $display("FAIL wrap_phase step %0d: got %0d expected %0d", s, phase_a, exp_ph[s]); end
    end
  endtask

  task automatic test_busy();
    int pulses;
    logic exp_done;
    logic [1:0] exp_ph;
    pulses = 0;
    for (int e = 0; e <= 26; e++) begin
      psen_a   = (e == 0) || (e == 1) || (e == 5) || (e == 12) || (e == 13);
      incdec_a = (e == 0) || (e == 13);   // ignored requests would decrement
      tick();
      if (e >= 1) begin
        exp_done = (e == 12) || (e == 25);
        exp_ph   = (e < 12) ? 2'd0 : ((e < 25) ? 2'd1 : 2'd2);
        if (psdone_a === 1'b1) pulses++;
        n_checks++;
        if (psdone_a !== exp_done) begin n_fail++; $display("FAIL busy_psdone edge +%0d: got %b expected %b", e, psdone_a, exp_done); end
        n_checks++;
        if (phase_a !== exp_ph) begin n_fail++; $display("FAIL busy_phase edge +%0d: got %0d expected %0d", e, phase_a, exp_ph); end
      end
    end
    psen_a = 1'b0; incdec_a = 1'b0;
    n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL busy_pulses: got %0d expected 2", pulses); end
  endtask

  task automatic test_reset_mid_shift();
    psen_a = 1'b1; incdec_a = 1'b1;
    tick();
    psen_a = 1'b0; incdec_a = 1'b0;
    repeat (6) tick();
    r_n = 1'b0;
    #1;
    n_checks++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %b expected 0", locked_a); end
    n_checks++; if (phase_a !== 2'd0) begin n_fail++; $display("FAIL midrst_phase: got %0d expected 0", phase_a); end
    n_checks++; if (clk_out_a !== 1'b0) begin n_fail++; $display("FAIL midrst_clk_out: got %b expected 0", clk_out_a); end
    n_checks++; if (locked_c !== 1'b0) begin n_fail++; $display("FAIL midrst_locked_c: got %b expected 0", locked_c); end
    repeat (3) tick();
    r_n = 1'b1;
    ecount = 0;
    for (int e = 1; e <= 30; e++) begin
      // Requests at edges 4 and 16 both see LOCKED=0 and must be dropped.
      psen_a   = (e == 4) || (e == 16);
      incdec_a = 1'b1;
      tick();
      n_checks++; if (psdone_a !== 1'b0) begin n_fail++; $display("FAIL relock_psdone edge %0d: got %b expected 0", e, psdone_a); end
      n_checks++; if (phase_a !== 2'd0) begin n_fail++; $display("FAIL relock_phase edge %0d: got %0d expected 0", e, phase_a); end
      n_checks++; if (locked_a !== (e >= 16)) begin n_fail++; $display("FAIL relock_locked edge %0d: got %b expected %b", e, locked_a, (e >= 16)); end
    end
    psen_a = 1'b0; incdec_a = 1'b0;
  endtask

  task automatic test_sweep();
    int highs;
    logic exp_clk;
    // DIVIDE=2 at phase 0: high when cnt==0.
    highs = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_clk = (ecount % 2) == 0;
      if (clk_out_b === 1'b1) highs++;
      n_checks++; if (clk_out_b !== exp_clk) begin n_fail++; $display("FAIL d2_clk ph0: got %b expected %b", clk_out_b, exp_clk); end
    end
    n_checks++; if (highs != 2) begin n_fail++; $display("FAIL d2_duty: got %0d expected 2", highs); end
    // Two increments at DIVIDE=2: 0 -> 1 -> 0, each exactly 2 edges.
    for (int s = 0; s < 2; s++) begin
      psen_b = 1'b1; incdec_b = 1'b1;
      tick();
      psen_b = 1'b0; incdec_b = 1'b0;
      tick();
      n_checks++; if (psdone_b !== 1'b0) begin n_fail++; $display("FAIL d2_psdone_early step %0d: got %b expected 0", s, psdone_b); end
      tick();
      n_checks++; if (psdone_b !== 1'b1) begin n_fail++; $display("FAIL d2_psdone step %0d: got %b expected 1", s, psdone_b); end
      n_checks++; if (phase_b !== 1'((s == 0) ? 1 : 0)) begin n_fail++; $display("FAIL d2_phase step %0d: got %0d expected %0d", s, phase_b, (s == 0) ? 1 : 0); end
      exp_clk = (s == 0) ? ((ecount % 2) == 1) : ((ecount % 2) == 0);
      n_checks++; if (clk_out_b !== exp_clk) begin n_fail++; $display("FAIL d2_clk step %0d: got %b expected %b", s, clk_out_b, exp_clk); end
    end
    // DIVIDE=8: decrement from 0 wraps to 7.
    psen_c = 1'b1; incdec_c = 1'b0;
    tick();
    psen_c = 1'b0;
    tick();
    n_checks++; if (psdone_c !== 1'b0) begin n_fail++; $display("FAIL d8_psdone_early: got %b expected 0", psdone_c); end
    tick();
    n_checks++; if (psdone_c !== 1'b1) begin n_fail++; $display("FAIL d8_psdone: got %b expected 1", psdone_c); end
    n_checks++; if (phase_c !== 3'd7) begin n_fail++; $display("FAIL d8_phase_dec: got %0d expected 7", phase_c); end
    // Phase 7: (cnt-7) mod 8 == (cnt+1) mod 8, high for cnt 7,0,1,2.
    highs = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      exp_clk = (((ecount % 8) + 1) % 8) < 4;
      if (clk_out_c === 1'b1) highs++;
      n_checks++; if (clk_out_c !== exp_clk) begin n_fail++; $display("FAIL d8_clk cnt %0d: got %b expected %b", ecount % 8, clk_out_c, exp_clk); end
    end
    n_checks++; if (highs != 4) begin n_fail++; $display("FAIL d8_duty: got %0d expected 4", highs); end
    // Increment from 7 wraps to 0.
    psen_c = 1'b1; incdec_c = 1'b1;
    tick();
    psen_c = 1'b0; incdec_c = 1'b0;
    tick();
    tick();
    n_checks++; if (psdone_c !== 1'b1) begin n_fail++; $display("FAIL d8_psdone_inc: got %b expected 1", psdone_c); end
    n_checks++; if (phase_c !== 3'd0) begin n_fail++; $display("FAIL d8_phase_inc: got %0d expected 0", phase_c); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ecount   = 0;
    r_n      = 1'b0;
    psen_a = 1'b0; incdec_a = 1'b0;
    psen_b = 1'b0; incdec_b = 1'b0;
    psen_c = 1'b0; incdec_c = 1'b0;
    test_reset();
    test_increment();
    test_wrap();
    test_busy();
    test_reset_mid_shift();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
